// File: rtl/uart_tx_port.sv
// Purpose: CPU-mapped UART transmitter with an 8-entry byte FIFO and a status register.
// Latency: the start bit reaches tx one clock after a push into an empty FIFO with the FSM idle.
// Backpressure: none on the bus. A push into a full FIFO is dropped and sets sticky overflow.
// Optional even parity bit is compiled in by defining UART_TX_PARITY_EN (11-bit frame instead of 10).
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hD000,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic        sel,
    output logic        tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    // Timer counts down from BIT_LAST to 0, so each bit is CLKS_PER_BIT cycles.
    localparam logic [15:0] BIT_LAST = CLKS_PER_BIT - 16'd1;

    // FIFO storage and bookkeeping
    logic [7:0]  fifo_mem [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q,  count_d;
    logic        overflow_q, overflow_d;

    // Transmit FSM state
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Bus decode and handshake between FIFO and FSM
    logic        wr_data_en;
    logic        wr_clr_en;
    logic        push_ok;
    logic        pop;
    logic        load;
    logic        fifo_empty;
    logic        fifo_full;
    logic        timer_last;
    logic        busy;
    logic [7:0]  head_dat;

    assign sel        = (address[15:1] == BASE_ADDR[15:1]);
    assign wr_data_en = sel & ~address[0] & ~read_write;
    assign wr_clr_en  = sel &  address[0] & ~read_write;
    assign fifo_empty = (count_q == 4'd0);
    assign fifo_full  = (count_q == 4'd8);
    assign timer_last = (timer_q == 16'd0);
    assign busy       = (state_q != S_IDLE);
    assign head_dat   = fifo_mem[rd_ptr_q];
    assign tx         = tx_q;

    // A full FIFO still accepts a push when the FSM pops in the same cycle,
    // because the freed slot is the one being written.
    assign push_ok    = wr_data_en & (~fifo_full | pop);

    // Status read mux; BASE+0 and unselected reads return zero
    always_comb begin
        data_read = 8'h00;
        if (sel && address[0] && read_write) begin
            data_read = {count_q, overflow_q, busy, fifo_full, fifo_empty};
        end
    end

    // FIFO pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {2'b00, push_ok};
        rd_ptr_d   = rd_ptr_q + {2'b00, pop};
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        if (wr_clr_en) begin
            overflow_d = 1'b0;
        end else if (wr_data_en && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Transmit FSM next-state; tx is computed here and registered so it is glitch-free
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = 16'd0;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (timer_last) begin
                    state_d = S_DATA;
                    timer_d = BIT_LAST;
                    tx_d    = shreg_q[0];
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_last) begin
                    timer_d = BIT_LAST;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (timer_last) begin
                    state_d = S_STOP;
                    timer_d = BIT_LAST;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (timer_last) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame, no idle gap
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        timer_d = 16'd0;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
                tx_d    = 1'b1;
            end
        endcase

        // Pop the FIFO head and begin a start bit
        if (load) begin
            state_d   = S_START;
            timer_d   = BIT_LAST;
            shreg_d   = head_dat;
            bit_idx_d = 3'd0;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head_dat;
`endif
        end
    end

    assign pop = load;

    // FIFO data storage; no reset needed since count gates validity
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            fifo_mem[wr_ptr_q] <= data_write;
        end
    end

    // All control state; reset aborts any frame and empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 3'd0;
            rd_ptr_q   <= 3'd0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            shreg_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hD000; register window base, with bit 0 required 0.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16'd434; clocks per serial bit, with a minimum of 2.
REQ-003 The block SHALL have port clk, input, 1 bit; the single system clock, rising edge, shared with the CPU.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port address, input, 16 bits; the CPU bus address.
REQ-006 The block SHALL have port read_write, input, 1 bit; 1 = CPU read, 0 = CPU write.
REQ-007 The block SHALL have port data_write, input, 8 bits; CPU write data.
REQ-008 The block SHALL have port data_read, output, 8 bits; register read data, combinational, for the system read mux.
REQ-009 The block SHALL have port sel, output, 1 bit; high when address[15:1] == BASE_ADDR[15:1], combinational.
REQ-010 The block SHALL have port tx, output, 1 bit; serial line, registered, idle high.

Function
REQ-011 A write to BASE+0 (sel=1, address[0]=0, read_write=0) SHALL push data_write into an 8-entry FIFO at that clock edge.
REQ-012 A write to BASE+1 SHALL clear the sticky overflow flag, and the data value SHALL be ignored.
REQ-013 A read of BASE+1 SHALL return the status byte {count[3:0], overflow, busy, full, empty}, with bit 0 = empty.
REQ-014 A read of BASE+0, and any read with sel=0, SHALL return data_read = 8'h00.
REQ-015 Reads SHALL have no side effects.
REQ-016 A push when count==8 with no pop in the same cycle SHALL be dropped, set overflow=1, and leave FIFO contents unchanged.
REQ-017 On a simultaneous push and pop with count==8, the push SHALL be accepted and count SHALL remain 8.
REQ-018 Count SHALL range 0..8, and FIFO pointers SHALL wrap modulo 8.
REQ-019 The transmit FSM SHALL have the states IDLE, START, DATA, PARITY (only if parity is compiled in), and STOP.
REQ-020 In IDLE with count>0, the FSM SHALL pop the FIFO head into the shift register and enter START at the next edge.
REQ-021 The first start bit SHALL appear on tx one cycle after the push edge when the FSM is IDLE and the FIFO is empty.
REQ-022 Each bit SHALL last exactly CLKS_PER_BIT cycles, using a bit-timer counter that reloads on every state change.
REQ-023 The frame SHALL be: start (0), then 8 data bits LSB first, then optional parity, then 1 stop bit (1).
REQ-024 At the end of STOP with count>0, the FSM SHALL pop and enter START directly, with no idle cycle between frames.
REQ-025 At the end of STOP with count==0, the FSM SHALL return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 tx SHALL be 1 in IDLE and STOP.

Reset
REQ-028 While rst=1, the block SHALL hold FSM=IDLE, tx=1, count=0, pointers=0, overflow=0, and bit timer=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, take effect at the next edge, and discard all FIFO contents.
REQ-030 A push coincident with rst=1 SHALL be ignored.
REQ-031 After reset, a read of BASE+1 SHALL return 8'h01.

Configuration
REQ-032 Parity SHALL be controlled by the macro UART_TX_PARITY_EN.
REQ-033 With UART_TX_PARITY_EN defined, the PARITY state SHALL send the XOR of the 8 data bits (even parity), giving a frame of 11*CLKS_PER_BIT cycles.
REQ-034 Without UART_TX_PARITY_EN, the PARITY state SHALL be absent and the frame SHALL be 10*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, BASE_ADDR=16'hD000)
REQ-035 Reset: assert rst for 2 cycles -> tx=1, and a read of D001 returns 8'h01.
REQ-036 Write 8'h55 to D000 -> tx=0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop=1; 40 cycles total (44 with parity, parity bit=0); status is then 8'h01.
REQ-037 Write 10 bytes to D000 on consecutive cycles -> first byte popped, 8 bytes queued, 10th dropped, D001 reads 8'h8E; then a write to D001 -> D001 reads 8'h86.
REQ-038 Write 8'hA0 then 8'h0F back-to-back -> the stop bit of the first frame is followed immediately by the start bit of the second; both bytes are received correctly by the serial monitor.
REQ-039 Write a byte, then assert rst during the third data bit -> tx=1 from the next edge, no further frame is sent, and D001 reads 8'h01.
REQ-040 With UART_TX_PARITY_EN defined, write 8'h07 -> parity bit=1, and the frame lasts 44 cycles.
